// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in, parallel-out deserializer.
package sipo_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } sipo_state_t;

    // Bit-count register width; the count only ever spans 0..width-1.
    function automatic int count_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit serial shift register with selectable shift direction and a
// synchronous clear; also exposes the value it would hold after one shift.
module sipo_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data_q,
    output logic [WIDTH-1:0] data_shifted
);

    logic [WIDTH-1:0] data_d;

    always_comb begin
        if (MSB_FIRST) begin
            data_shifted = {data_q[WIDTH-2:0], bit_in};
        end else begin
            data_shifted = {bit_in, data_q[WIDTH-1:1]};
        end

        data_d = data_q;
        if (clear) begin
            data_d = '0;
        end else if (shift_en) begin
            data_d = data_shifted;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the next
    // value is computed in always_comb so this block stays a plain register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer: bit handshake in, registered word
// handshake out, with a one-word HOLD state to absorb output backpressure.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready
);

    localparam int             CW   = count_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    sipo_state_t      state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] word_out_q, word_out_d;
    logic             word_valid_q, word_valid_d;

    logic             shift_en;
    logic             slot_free;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_shifted;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .shift_en     (shift_en),
        .bit_in       (bit_in),
        .data_q       (sreg_q),
        .data_shifted (sreg_shifted)
    );

    assign slot_free  = !word_valid_q || word_ready;
    assign bit_ready  = (state_q == COLLECT);
    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_out_d   = word_out_q;
        word_valid_d = word_valid_q && !word_ready;
        shift_en     = 1'b0;

        if (clear) begin
            // Abort beats a same-cycle bit; the output register is untouched.
            state_d = COLLECT;
            count_d = '0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (bit_valid) begin
                        shift_en = 1'b1;
                        if (count_q == LAST) begin
                            count_d = '0;
                            if (slot_free) begin
                                word_out_d   = sreg_shifted;
                                word_valid_d = 1'b1;
                            end else begin
                                state_d = HOLD;
                            end
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        word_out_d   = sreg_q;
                        word_valid_d = 1'b1;
                        state_d      = COLLECT;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= COLLECT;
            count_q      <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: an MSB-first and an LSB-first
// instance share stimulus; consumed words are checked against queues.
module tb_sipo_deserializer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             word_ready = 1'b0;

    logic             bit_ready_m, bit_ready_l;
    logic [WIDTH-1:0] word_out_m, word_out_l;
    logic             word_valid_m, word_valid_l;

    int errors = 0;
    int checks = 0;
    int pushed = 0;
    int popped = 0;

    logic [WIDTH-1:0] exp_q_m[$];
    logic [WIDTH-1:0] exp_q_l[$];

    always #10 clk = ~clk;

    sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready_m),
        .word_out   (word_out_m),
        .word_valid (word_valid_m),
        .word_ready (word_ready)
    );

    sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready_l),
        .word_out   (word_out_l),
        .word_valid (word_valid_l),
        .word_ready (word_ready)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    // Scoreboard: compare every consumed word with the oldest expected one.
    always @(negedge clk) begin
        if (!rst && word_ready) begin
            if (word_valid_m) begin
                check("msb_queue_nonempty", 32'(exp_q_m.size() > 0), 32'd1);
                if (exp_q_m.size() > 0) begin
                    check("msb_word", 32'(word_out_m), 32'(exp_q_m.pop_front()));
                    popped++;
                end
            end
            if (word_valid_l) begin
                check("lsb_queue_nonempty", 32'(exp_q_l.size() > 0), 32'd1);
                if (exp_q_l.size() > 0) begin
                    check("lsb_word", 32'(word_out_l), 32'(exp_q_l.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bit and hold it until it is accepted (bounded wait).
    task automatic send_bit(input logic b);
        int budget = 0;
        bit_in    = b;
        bit_valid = 1'b1;
        while (!bit_ready_m && budget < 50) begin
            tick();
            budget++;
        end
        if (budget >= 50) check("bit_ready_timeout", 32'(bit_ready_m), 32'd1);
        tick();
        bit_valid = 1'b0;
    endtask

    // seq[WIDTH-1] goes on the wire first; expectations are queued as the
    // last bit is driven.
    task automatic send_word(input logic [WIDTH-1:0] seq, input bit gapped);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i == 0) begin
                exp_q_m.push_back(seq);
                exp_q_l.push_back(reverse(seq));
                pushed++;
            end
            send_bit(seq[i]);
            if (gapped) begin
                bit_in = ~seq[i];
                tick();
            end
        end
    endtask

    initial begin
        // Reset state
        #25;
        check("reset_word_valid", 32'(word_valid_m), 32'd0);
        check("reset_word_out", 32'(word_out_m), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_bit_ready", 32'(bit_ready_m), 32'd1);

        // 1: MSB-first 0xA5 with the output always ready
        word_ready = 1'b1;
        tick();
        send_word(8'hA5, 1'b0);
        check("t1_valid_after_8th", 32'(word_valid_m), 32'd1);
        check("t1_word_msb", 32'(word_out_m), 32'hA5);
        check("t1_word_lsb", 32'(word_out_l), 32'(reverse(8'hA5)));
        check("t1_bit_ready", 32'(bit_ready_m), 32'd1);
        tick();
        check("t1_valid_one_cycle", 32'(word_valid_m), 32'd0);

        // 2: bits 0,0,0,1,1,1,1,0 -> 0x1E MSB-first, 0x78 LSB-first
        send_word(8'h1E, 1'b0);
        check("t2_word_msb", 32'(word_out_m), 32'h1E);
        check("t2_word_lsb", 32'(word_out_l), 32'h78);
        tick();

        // 3: backpressure, two words back to back, second one held
        word_ready = 1'b0;
        send_word(8'h3C, 1'b0);
        check("t3_first_word", 32'(word_out_m), 32'h3C);
        check("t3_first_valid", 32'(word_valid_m), 32'd1);
        send_word(8'hC3, 1'b0);
        check("t3_hold_bit_ready", 32'(bit_ready_m), 32'd0);
        check("t3_hold_bit_ready_lsb", 32'(bit_ready_l), 32'd0);
        tick();
        tick();
        check("t3_word_stable", 32'(word_out_m), 32'h3C);
        check("t3_still_hold", 32'(bit_ready_m), 32'd0);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("t3_second_word", 32'(word_out_m), 32'hC3);
        check("t3_valid_kept", 32'(word_valid_m), 32'd1);
        check("t3_ready_back", 32'(bit_ready_m), 32'd1);
        word_ready = 1'b1;
        tick();
        tick();

        // 4: clear after 3 bits, clear wins over a same-cycle bit
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        clear     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        clear     = 1'b0;
        bit_valid = 1'b0;
        send_word(8'h5A, 1'b0);
        check("t4_word_after_clear", 32'(word_out_m), 32'h5A);
        tick();

        // 5: asynchronous reset mid-word, with an unconsumed word pending
        word_ready = 1'b0;
        send_word(8'h96, 1'b0);
        check("t5_pending_valid", 32'(word_valid_m), 32'd1);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        #5;
        rst = 1'b1;
        #1;
        check("t5_async_valid", 32'(word_valid_m), 32'd0);
        check("t5_async_word", 32'(word_out_m), 32'd0);
        exp_q_m.delete();
        exp_q_l.delete();
        pushed--;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_bit_ready", 32'(bit_ready_m), 32'd1);
        word_ready = 1'b1;
        send_word(8'hFF, 1'b0);
        check("t5_word_ff", 32'(word_out_m), 32'hFF);
        tick();

        // 6: gaps between bits, garbage on bit_in while bit_valid is low
        send_word(8'h81, 1'b1);
        check("t6_word_gapped", 32'(word_out_m), 32'h81);
        check("t6_word_gapped_lsb", 32'(word_out_l), 32'h81);

        // Back-to-back words with no bubbles
        send_word(8'h12, 1'b0);
        check("tp_first_valid", 32'(word_valid_m), 32'd1);
        send_word(8'h34, 1'b0);
        check("tp_second_word", 32'(word_out_m), 32'h34);
        tick();
        tick();
        tick();

        check("drain_queue_msb", 32'(exp_q_m.size()), 32'd0);
        check("drain_queue_lsb", 32'(exp_q_l.size()), 32'd0);
        check("words_consumed", 32'(popped), 32'(pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in, parallel-out deserializer. It is the receive-side counterpart of the mux-register parallel-load shift chain used elsewhere in the design. It accepts one bit per cycle under a valid/ready handshake and assembles WIDTH-bit words. Completed words are presented on a registered parallel output with its own valid/ready handshake. A one-word hold state absorbs output backpressure without losing bits.

Parameters:
- WIDTH, 8: word length in bits; must be ≥ 2.
- MSB_FIRST, 1: 1 = first received bit lands in word_out[WIDTH-1]; 0 = first received bit lands in word_out[0].

Ports:
- Clock  input  1  system clock (50 MHz); all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Clear  input  1  synchronous abort of the word being assembled.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  block accepts a bit this cycle.
- word_out  output  WIDTH  assembled parallel word (registered).
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  downstream consumes word_out this cycle.

Behaviour:
- Reset (asynchronous, active-high, any time including mid-word):
  - state ← COLLECT, bit count ← 0, shift register ← 0.
  - word_out ← 0, word_valid ← 0, bit_ready = 1 once Reset deasserts.
- Handshake events:
  - Bit accept occurs on an edge where bit_valid && bit_ready.
  - Word consume occurs on an edge where word_valid && word_ready.
  - bit_valid may drop at any time; gaps between bits are allowed and do not disturb the count.
- Output slot "free" this cycle = !word_valid || word_ready.
- States:
  - COLLECT: bit_ready = 1.
    - Accepted bit shifts into the shift register. MSB_FIRST=1 shifts left with the new bit at LSB; MSB_FIRST=0 shifts right with the new bit at MSB. Count increments.
    - On accept of bit number WIDTH (count == WIDTH-1):
      - if slot free: word_out ← completed word, word_valid ← 1 on that same edge, count ← 0, stay in COLLECT;
      - otherwise: count ← 0, go to HOLD, shift register keeps the full word.
  - HOLD: bit_ready = 0.
    - On the first edge where the slot is free: word_out ← held word, word_valid ← 1, go to COLLECT.
- Latency: word_valid rises in the cycle immediately after the edge that accepts the last bit, provided the slot is free. With word_ready held at 1, sustained throughput is one word per WIDTH accepted bits with no bubbles.
- word_valid and word_out:
  - word_valid falls after a consume unless a new word loads on the same edge; a simultaneous load and consume keeps word_valid = 1 with the new data.
  - word_out is stable while word_valid && !word_ready.
- Clear:
  - Takes priority over a bit accept in the same cycle.
  - count ← 0, state ← COLLECT; the partial word or the word held in HOLD is discarded.
  - Does not affect word_out or word_valid.
- Count register width: $clog2(WIDTH). Count never reaches WIDTH.

Decomposition:
- Shared package sipo_pkg holds:
  - state enum sipo_state_t {COLLECT, HOLD};
  - localparam function for the count width.
- Natural sub-module: sipo_shift_reg. It is the WIDTH-bit shift register with a direction parameter, shift enable and synchronous clear. The top level holds the FSM, the counter and the output register.

Test Plan (WIDTH=8):
1. MSB_FIRST=1, word_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles → word_out=0xA5 and word_valid=1 for exactly one cycle, starting the cycle after the 8th accept; bit_ready stays 1 throughout.
2. MSB_FIRST=0, bits 0,0,0,1,1,1,1,0 → word_out=0x78. The same bits with MSB_FIRST=1 → 0x1E.
3. word_ready=0; send 0x3C then 0xC3 back-to-back:
   - word_out=0x3C after the first word;
   - after the 16th bit, HOLD is entered and bit_ready=0.
   - Raise word_ready for one cycle → next edge word_out=0xC3, word_valid stays 1, bit_ready=1.
4. Clear asserted after 3 bits, then 8 bits of 0x5A → word_out=0x5A; no stale bits appear.
5. Reset pulsed mid-word (after 5 bits) and asynchronously between edges:
   - word_valid=0 and word_out=0 immediately;
   - the next 8 bits of 0xFF → 0xFF.
6. bit_valid toggled 1,0,1,0… while sending 0x81 → word_out=0x81 after the 8th valid bit; gaps have no effect.
